voice_allocator: RTL and testbench

- Upstream of the per-voice oscillator/ADSR stage: converts a stream of MIDI note-on/note-off events into a shared 32-bit DDS tuning-code bus plus one key_state line per voice.
- Assigns a note-on to a free voice, or steals the least-recently-started voice when none is free.
- Sequences the shared bus so each voice sees a stable tuning code before its key_state rises, since voices latch the bus on the rising edge of key_state.

---
 rtl/voice_alloc_pkg.sv | 22 ++
 rtl/note_tuning_rom.sv | 28 ++
 rtl/voice_allocator.sv | 164 ++++++++++++++++
 tb/tb_voice_allocator.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the voice allocator: FSM states and the
// top-octave DDS tuning codes (notes 120..131 at a 50 MHz DDS clock).
package voice_alloc_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_ALLOC,
    ST_GAP,
    ST_KEYON
  } state_t;

  // round(f * 2^32 / CLK_HZ) for C9..B9; lower octaves are right shifts of these.
  localparam logic [31:0] BASE_TUNING [12] = '{
    32'd719151,  32'd761914,  32'd807220,  32'd855219,
    32'd906073,  32'd959951,  32'd1017033, 32'd1077509,
    32'd1141581, 32'd1209463, 32'd1281381, 32'd1357576
  };

endpackage

// File: rtl/note_tuning_rom.sv
// MIDI note to DDS phase increment: semitone picks a top-octave code, octave
// sets the right shift. Output is registered (one cycle latency).
module note_tuning_rom
  import voice_alloc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  note,
  output logic [31:0] code
);

  logic [3:0] semitone;
  logic [3:0] octave;
  logic [3:0] shift;

  assign semitone = 4'(note % 7'd12);
  assign octave   = 4'(note / 7'd12);
  assign shift    = 4'd10 - octave;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code <= '0;
    end else begin
      code <= BASE_TUNING[semitone] >> shift;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Turns note-on/off events into a shared tuning bus plus per-voice key lines,
// making sure the bus is settled before any key_state rising edge.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int AGE_W      = 4,
  parameter int STEAL_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  note_valid,
  output logic                  note_ready,
  input  logic                  note_on,
  input  logic [6:0]            note_num,
  input  logic                  panic,
  output logic [31:0]           tuning_code,
  output logic [NUM_VOICES-1:0] key_state,
  output logic                  steal_pulse
);

  localparam int VID_W = $clog2(NUM_VOICES);
  localparam int GAP_W = (STEAL_GAP > 1) ? $clog2(STEAL_GAP) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_t                state_reg, state_next;
  logic                  on_reg;
  logic [6:0]            evt_note_reg;
  logic [VID_W-1:0]      voice_reg;
  logic [GAP_W-1:0]      gap_reg;
  logic [31:0]           tuning_reg;
  logic                  steal_reg;
  logic [31:0]           rom_code;
  logic                  accept;

  logic [NUM_VOICES-1:0] key_vec;
  logic [NUM_VOICES-1:0] match_vec;
  logic [AGE_W-1:0]      age_arr [NUM_VOICES];
  logic [VID_W-1:0]      match_idx, free_idx, old_idx, target;
  logic [AGE_W-1:0]      old_age;
  logic                  target_busy, target_steal;

  assign accept      = note_valid & note_ready;
  assign tuning_code = tuning_reg;
  assign key_state   = key_vec;
  assign steal_pulse = steal_reg;

  note_tuning_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .note  (evt_note_reg),
    .code  (rom_code)
  );

  // Target priority: retrigger of a sounding note, lowest free voice, oldest voice.
  always_comb begin
    match_idx    = '0;
    free_idx     = '0;
    old_idx      = '0;
    old_age      = age_arr[0];
    target       = '0;
    target_busy  = 1'b1;
    target_steal = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (match_vec[i]) match_idx = VID_W'(i);
      if (!key_vec[i])  free_idx  = VID_W'(i);
    end
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_arr[i] > old_age) begin
        old_age = age_arr[i];
        old_idx = VID_W'(i);
      end
    end
    if (|match_vec) begin
      target = match_idx;
    end else if (!(&key_vec)) begin
      target      = free_idx;
      target_busy = 1'b0;
    end else begin
      target       = old_idx;
      target_steal = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    logic             key_reg;
    logic [AGE_W-1:0] age_reg;
    logic [6:0]       note_reg;

    assign key_vec[gi]   = key_reg;
    assign age_arr[gi]   = age_reg;
    assign match_vec[gi] = key_reg && (note_reg == evt_note_reg);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        key_reg  <= 1'b0;
        age_reg  <= '0;
        note_reg <= '0;
      end else if (panic) begin
        key_reg <= 1'b0;
      end else if (state_reg == ST_ALLOC) begin
        if (on_reg ? (target_busy && target == VID_W'(gi)) : match_vec[gi])
          key_reg <= 1'b0;
      end else if (state_reg == ST_KEYON) begin
        if (voice_reg == VID_W'(gi)) begin
          key_reg  <= 1'b1;
          age_reg  <= '0;
          note_reg <= evt_note_reg;
        end else if (age_reg != AGE_MAX) begin
          age_reg <= age_reg + AGE_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    note_ready = (state_reg == ST_IDLE) && !panic;
    unique case (state_reg)
      ST_IDLE:   if (accept) state_next = ST_LOOKUP;
      ST_LOOKUP: state_next = ST_ALLOC;
      ST_ALLOC: begin
        if (!on_reg)          state_next = ST_IDLE;
        else if (target_busy) state_next = ST_GAP;
        else                  state_next = ST_KEYON;
      end
      ST_GAP:    if (gap_reg == '0) state_next = ST_KEYON;
      ST_KEYON:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (panic) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      on_reg       <= 1'b0;
      evt_note_reg <= '0;
      voice_reg    <= '0;
      gap_reg      <= '0;
      tuning_reg   <= '0;
      steal_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      steal_reg <= 1'b0;
      if (accept) begin
        on_reg       <= note_on;
        evt_note_reg <= note_num;
      end
      // panic freezes tuning and the gap counter; the FSM is already forced idle
      if (!panic) begin
        if (state_reg == ST_ALLOC && on_reg) begin
          voice_reg  <= target;
          tuning_reg <= rom_code;
          gap_reg    <= GAP_W'(STEAL_GAP - 1);
          steal_reg  <= target_steal;
        end
        if (state_reg == ST_GAP && gap_reg != '0)
          gap_reg <= gap_reg - GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed table, hand-written corner sequences and
// random events checked against a voice-list reference model.
module tb_voice_allocator;

  localparam int NV = 8;
  localparam int SG = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          note_valid = 1'b0;
  logic          note_on = 1'b0;
  logic [6:0]    note_num = '0;
  logic          panic = 1'b0;
  logic          note_ready;
  logic [31:0]   tuning_code;
  logic [NV-1:0] key_state;
  logic          steal_pulse;

  int checks = 0;
  int failures = 0;

  // reference model: per-voice note, gate and age, plus current bus value
  bit          m_key  [NV];
  int          m_note [NV];
  int          m_age  [NV];
  logic [31:0] m_code;

  typedef struct {
    bit          on;
    int          note;
    logic [7:0]  key;
    logic [31:0] code;
    bit          steal;
  } vec_t;

  vec_t tbl [15];

  always #10 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(4), .STEAL_GAP(SG)) dut (
    .clk         (clk),
    .reset       (reset),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_on     (note_on),
    .note_num    (note_num),
    .panic       (panic),
    .tuning_code (tuning_code),
    .key_state   (key_state),
    .steal_pulse (steal_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Equal-tempered frequency scaled to a 32-bit phase increment at 50 MHz.
  function automatic logic [31:0] ref_code(input int n);
    real f;
    real inc;
    int  k;
    int  oct;
    logic [31:0] base;
    k    = n % 12;
    oct  = n / 12;
    f    = 440.0 * (2.0 ** ((real'(120 + k) - 69.0) / 12.0));
    inc  = f * 4294967296.0 / 50.0e6;
    base = 32'($rtoi(inc + 0.5));
    return base >> (10 - oct);
  endfunction

  function automatic logic [NV-1:0] model_keys();
    logic [NV-1:0] k;
    for (int i = 0; i < NV; i++) k[i] = m_key[i];
    return k;
  endfunction

  function automatic int pick(input int note, output bit busy, output bit stl);
    int best;
    busy = 1'b1;
    stl  = 1'b0;
    for (int i = 0; i < NV; i++)
      if (m_key[i] && m_note[i] == note) return i;
    for (int i = 0; i < NV; i++)
      if (!m_key[i]) begin
        busy = 1'b0;
        return i;
      end
    stl  = 1'b1;
    best = 0;
    for (int i = 1; i < NV; i++)
      if (m_age[i] > m_age[best]) best = i;
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_key[i]  = 1'b0;
      m_note[i] = 0;
      m_age[i]  = 0;
    end
    m_code = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Issue one event and check every cycle until it is fully applied.
  task automatic do_event(input bit on, input int note, output bit saw_steal);
    logic [NV-1:0] pre_key, mid_key, fin_key;
    logic [31:0]   pre_code, exp_code;
    int            v, lat, waited;
    bit            busy, stl;
    saw_steal = 1'b0;
    waited = 0;
    while (note_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_event", 32'(note_ready), 32'd1);
    pre_key  = model_keys();
    pre_code = m_code;
    note_valid = 1'b1;
    note_on    = on;
    note_num   = 7'(note);
    @(negedge clk);
    note_valid = 1'b0;
    note_on    = 1'($urandom_range(0, 1));
    note_num   = 7'($urandom_range(0, 127));
    chk("lookup_ready", 32'(note_ready), 32'd0);
    chk("lookup_key", 32'(key_state), 32'(pre_key));
    @(negedge clk);
    chk("alloc_ready", 32'(note_ready), 32'd0);
    chk("alloc_tuning", tuning_code, pre_code);
    @(negedge clk);
    v = 0; busy = 1'b0; stl = 1'b0; lat = 0;
    if (on) begin
      v        = pick(note, busy, stl);
      exp_code = ref_code(note);
      mid_key  = busy ? (pre_key & ~(NV'(1) << v)) : pre_key;
      fin_key  = pre_key | (NV'(1) << v);
      lat      = busy ? SG : 0;
    end else begin
      exp_code = pre_code;
      mid_key  = pre_key;
      for (int i = 0; i < NV; i++)
        if (m_key[i] && m_note[i] == note) mid_key[i] = 1'b0;
      fin_key  = mid_key;
    end
    chk("t2_tuning", tuning_code, exp_code);
    chk("t2_steal", 32'(steal_pulse), 32'(stl));
    chk("t2_key", 32'(key_state), 32'(mid_key));
    chk("t2_ready", 32'(note_ready), on ? 32'd0 : 32'd1);
    saw_steal = steal_pulse;
    if (on) begin
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        chk("gap_key", 32'(key_state), 32'(mid_key));
        chk("gap_tuning", tuning_code, exp_code);
        chk("gap_steal", 32'(steal_pulse), 32'd0);
      end
      @(negedge clk);
      chk("keyon_key", 32'(key_state), 32'(fin_key));
      chk("keyon_ready", 32'(note_ready), 32'd1);
      chk("keyon_steal", 32'(steal_pulse), 32'd0);
      for (int i = 0; i < NV; i++)
        if (i != v && m_age[i] < 15) m_age[i]++;
      m_age[v]  = 0;
      m_key[v]  = 1'b1;
      m_note[v] = note;
      m_code    = exp_code;
    end else begin
      for (int i = 0; i < NV; i++)
        if (m_note[i] == note) m_key[i] = 1'b0;
    end
    $display("event on=%0d note=%0d voice=%0d steal=%0d key=%b code=%0d",
             on, note, v, saw_steal, key_state, tuning_code);
  endtask

  initial begin
    bit saw;
    int n;

    tbl[0]  = '{1'b1, 69, 8'h01, 32'd37795, 1'b0};
    tbl[1]  = '{1'b0, 69, 8'h00, 32'd37795, 1'b0};
    tbl[2]  = '{1'b1, 60, 8'h01, 32'd22473, 1'b0};
    tbl[3]  = '{1'b1, 64, 8'h03, 32'd28314, 1'b0};
    tbl[4]  = '{1'b1, 67, 8'h07, 32'd33672, 1'b0};
    tbl[5]  = '{1'b0, 64, 8'h05, 32'd33672, 1'b0};
    tbl[6]  = '{1'b1, 60, 8'h05, 32'd22473, 1'b0};
    tbl[7]  = '{1'b0, 61, 8'h05, 32'd22473, 1'b0};
    tbl[8]  = '{1'b1, 61, 8'h07, 32'd23809, 1'b0};
    tbl[9]  = '{1'b1, 62, 8'h0F, 32'd25225, 1'b0};
    tbl[10] = '{1'b1, 63, 8'h1F, 32'd26725, 1'b0};
    tbl[11] = '{1'b1, 64, 8'h3F, 32'd28314, 1'b0};
    tbl[12] = '{1'b1, 65, 8'h7F, 32'd29998, 1'b0};
    tbl[13] = '{1'b1, 66, 8'hFF, 32'd31782, 1'b0};
    tbl[14] = '{1'b1, 72, 8'hFF, 32'd44946, 1'b1};

    model_reset();
    #5;
    chk("reset_key", 32'(key_state), 32'd0);
    chk("reset_tuning", tuning_code, 32'd0);
    chk("reset_steal", 32'(steal_pulse), 32'd0);
    chk("reset_ready", 32'(note_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      do_event(tbl[i].on, tbl[i].note, saw);
      chk($sformatf("tbl%0d_key", i), 32'(key_state), 32'(tbl[i].key));
      chk($sformatf("tbl%0d_code", i), tuning_code, tbl[i].code);
      chk($sformatf("tbl%0d_steal", i), 32'(saw), 32'(tbl[i].steal));
    end

    // fill all voices in order, then the oldest (voice 0) is stolen
    do_reset();
    for (int i = 0; i < NV; i++) do_event(1'b1, 60 + i, saw);
    do_event(1'b1, 72, saw);
    chk("steal_seen", 32'(saw), 32'd1);
    chk("steal_key", 32'(key_state), 32'hFF);
    chk("steal_code", tuning_code, 32'd44946);

    // panic while the retriggered voice is in its gap
    do_reset();
    do_event(1'b1, 60, saw);
    note_valid = 1'b1; note_on = 1'b1; note_num = 7'd60;
    @(negedge clk);
    note_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pgap_key", 32'(key_state), 32'd0);
    panic = 1'b1;
    #1;
    chk("panic_ready", 32'(note_ready), 32'd0);
    @(negedge clk);
    chk("panic_key", 32'(key_state), 32'd0);
    chk("panic_tuning", tuning_code, ref_code(60));
    panic = 1'b0;
    #1;
    chk("post_panic_ready", 32'(note_ready), 32'd1);
    repeat (SG + 3) @(negedge clk);
    chk("post_panic_key", 32'(key_state), 32'd0);
    for (int i = 0; i < NV; i++) m_key[i] = 1'b0;

    // valid together with panic must not be accepted
    note_valid = 1'b1; note_on = 1'b1; note_num = 7'd70; panic = 1'b1;
    #1;
    chk("valid_panic_ready", 32'(note_ready), 32'd0);
    @(negedge clk);
    note_valid = 1'b0; panic = 1'b0;
    repeat (5) @(negedge clk);
    chk("valid_panic_key", 32'(key_state), 32'(model_keys()));
    chk("valid_panic_tuning", tuning_code, m_code);
    do_event(1'b1, 61, saw);
    chk("after_panic_voice0", 32'(key_state), 32'h01);

    // range extremes of the tuning table
    do_event(1'b1, 0, saw);
    chk("note0_code", tuning_code, 32'd702);
    do_event(1'b1, 127, saw);
    chk("note127_code", tuning_code, 32'd1077509);

    // async reset during the KEYON cycle
    do_reset();
    note_valid = 1'b1; note_on = 1'b1; note_num = 7'd62;
    @(negedge clk);
    note_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("keyon_pre_tuning", tuning_code, 32'd25225);
    chk("keyon_pre_key", 32'(key_state), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_key", 32'(key_state), 32'd0);
    chk("async_tuning", tuning_code, 32'd0);
    chk("async_ready", 32'(note_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("async_after_key", 32'(key_state), 32'd0);

    // random events against the model
    for (int i = 0; i < 80; i++) begin
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(55, 66));
      do_event(($urandom_range(0, 9) < 7), n, saw);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
